sram_test: RTL and testbench

SRAM_TEST -- requirements
Module: sram_test

---
 rtl/sram_test_pkg.sv | 18 +
 rtl/sram_pattern_gen.sv | 24 ++
 rtl/sram_test.sv | 143 ++++++++++++++
 tb/tb_sram_test.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_test_pkg.sv
// Shared definitions for the SRAM march-style write/read self test.
package sram_test_pkg;

    localparam int SRAM_DATA_W = 16;
    localparam logic [SRAM_DATA_W-1:0] PATTERN = 16'hA5A5;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t WR_SETUP = 3'd1;
    localparam state_t WR_PULSE = 3'd2;
    localparam state_t WR_HOLD  = 3'd3;
    localparam state_t RD_SETUP = 3'd4;
    localparam state_t RD_WAIT  = 3'd5;
    localparam state_t RD_CMP   = 3'd6;
    localparam state_t DONE     = 3'd7;

endpackage

// File: rtl/sram_pattern_gen.sv
// Address-to-test-word mapping: low 16 address bits (zero-extended) XOR PATTERN.
module sram_pattern_gen
    import sram_test_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [SRAM_DATA_W-1:0] data
);

    logic [15:0] addr16;

    if (ADDR_W >= 16) begin : g_wide
        assign addr16 = addr[15:0];
    end else begin : g_narrow
        assign addr16 = {{(16 - ADDR_W){1'b0}}, addr};
    end

    // Pure XOR mask, no state.
    always_comb begin
        data = addr16 ^ PATTERN;
    end

endmodule

// File: rtl/sram_test.sv
// Full-array SRAM self test: one write pass of the address pattern, then one
// read/compare pass, then hold DONE with a pass flag and saturating error count.
module sram_test
    import sram_test_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    output logic              test_done,
    output logic              test_pass,
    output logic [15:0]       err_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [15:0]       err_nxt;
    logic              armed;
    logic              bus_drive;
    logic [DATA_W-1:0] exp_data;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // One pattern source serves both the write drive and the read compare,
    // since the address register is stable across each 3-cycle access.
    sram_pattern_gen #(.ADDR_W(ADDR_W)) u_pattern (
        .addr (sram_addr),
        .data (exp_data)
    );

    assign sram_data = bus_drive ? exp_data : {DATA_W{1'bz}};

    // Next-state, next-address and error-count logic.
    always_comb begin
        state_nxt = state;
        addr_nxt  = sram_addr;
        err_nxt   = err_cnt;
        case (state)
            IDLE: begin
                addr_nxt = '0;
                if (armed) state_nxt = WR_SETUP;
            end
            WR_SETUP: state_nxt = WR_PULSE;
            WR_PULSE: state_nxt = WR_HOLD;
            WR_HOLD: begin
                if (sram_addr == LAST_ADDR) begin
                    addr_nxt  = '0;
                    state_nxt = RD_SETUP;
                end else begin
                    addr_nxt  = sram_addr + 1'b1;
                    state_nxt = WR_SETUP;
                end
            end
            RD_SETUP: state_nxt = RD_WAIT;
            RD_WAIT:  state_nxt = RD_CMP;
            RD_CMP: begin
                if (sram_data != exp_data) err_nxt = sat_inc(err_cnt);
                if (sram_addr == LAST_ADDR) begin
                    state_nxt = DONE;
                end else begin
                    addr_nxt  = sram_addr + 1'b1;
                    state_nxt = RD_SETUP;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and all SRAM strobes registered from the next state,
    // so strobes and bus enable change together on the clock edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            bus_drive <= 1'b0;
            test_done <= 1'b0;
            test_pass <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            armed     <= 1'b1;
            sram_addr <= addr_nxt;
            err_cnt   <= err_nxt;
            test_done <= (state_nxt == DONE);
            test_pass <= (state_nxt == DONE) && (err_nxt == 16'd0);
            case (state_nxt)
                WR_SETUP, WR_HOLD: begin
                    sram_ce_n <= 1'b0;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    sram_ub_n <= 1'b0;
                    sram_lb_n <= 1'b0;
                    bus_drive <= 1'b1;
                end
                WR_PULSE: begin
                    sram_ce_n <= 1'b0;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b0;
                    sram_ub_n <= 1'b0;
                    sram_lb_n <= 1'b0;
                    bus_drive <= 1'b1;
                end
                RD_SETUP, RD_WAIT, RD_CMP: begin
                    sram_ce_n <= 1'b0;
                    sram_oe_n <= 1'b0;
                    sram_we_n <= 1'b1;
                    sram_ub_n <= 1'b0;
                    sram_lb_n <= 1'b0;
                    bus_drive <= 1'b0;
                end
                default: begin
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    bus_drive <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_test.sv
// Bench for sram_test with a behavioural async SRAM (16 words) and fault injection.
module tb_sram_test;

    localparam int AW       = 4;
    localparam int N        = 1 << AW;
    localparam int DONE_CYC = 1 + 6 * N;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    wire  [15:0]   sram_data;
    logic [AW-1:0] sram_addr;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic          test_done, test_pass;
    logic [15:0]   err_cnt;

    always #5 sys_clk = ~sys_clk;

    sram_test #(.ADDR_W(AW), .DATA_W(16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n),
        .test_done (test_done),
        .test_pass (test_pass),
        .err_cnt   (err_cnt)
    );

    // ---------------- behavioural SRAM with fault injection ----------------
    logic [15:0] mem [N];
    bit          stuck_en;
    logic [3:0]  stuck_bit;
    bit          ignore_en;
    int          ignore_addr;
    logic [15:0] rd_raw, rd_val;

    assign rd_raw    = mem[sram_addr];
    assign rd_val    = stuck_en ? (rd_raw & ~(16'h1 << stuck_bit)) : rd_raw;
    assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? rd_val : 16'hzzzz;

    always @(negedge sys_clk) begin
        if (!sys_rst && !sram_ce_n && !sram_we_n &&
            !(ignore_en && int'(sram_addr) == ignore_addr))
            mem[sram_addr] = sram_data;
    end

    // ---------------- reference rules ----------------
    function automatic logic [15:0] pat(input int a);
        return 16'(a) ^ 16'hA5A5;
    endfunction

    function automatic int ref_errs(input bit s_en, input int s_bit,
                                    input bit i_en, input int i_addr);
        int e = 0;
        for (int a = 0; a < N; a++) begin
            logic [15:0] stored, seen;
            stored = (i_en && a == i_addr) ? 16'h0000 : pat(a);
            seen   = s_en ? (stored & ~(16'h1 << s_bit)) : stored;
            if (seen != pat(a)) e++;
        end
        return (e > 65535) ? 65535 : e;
    endfunction

    // ---------------- protocol monitor ----------------
    bit mon_en = 1'b0;
    int wr_pulses, wr_cycles, rd_cycles, mon_viol, next_wr;
    bit prev_we_low;

    always @(negedge sys_clk) begin
        if (mon_en && !sys_rst) begin
            if (!sram_ce_n && (sram_ub_n || sram_lb_n)) mon_viol++;
            if (!sram_oe_n && (!sram_we_n || sram_data !== rd_val)) mon_viol++;
            if (!sram_ce_n && sram_oe_n) begin
                wr_cycles++;
                if (sram_data !== pat(int'(sram_addr))) mon_viol++;
            end
            if (!sram_ce_n && !sram_oe_n) rd_cycles++;
            if (!sram_we_n) begin
                wr_pulses++;
                if (prev_we_low) mon_viol++;
                if (int'(sram_addr) != next_wr) mon_viol++;
                next_wr++;
            end
            prev_we_low = !sram_we_n;
        end
    end

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " addr"},   int'(sram_addr), 0);
        check({tag, " ce_n"},   int'(sram_ce_n), 1);
        check({tag, " oe_n"},   int'(sram_oe_n), 1);
        check({tag, " we_n"},   int'(sram_we_n), 1);
        check({tag, " ub_lb"},  int'({sram_ub_n, sram_lb_n}), 3);
        check({tag, " done"},   int'(test_done), 0);
        check({tag, " pass"},   int'(test_pass), 0);
        check({tag, " errcnt"}, int'(err_cnt), 0);
    endtask

    // Holds reset 3 cycles, checks reset outputs, clears memory/monitor, releases.
    task automatic do_reset(input string tag);
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_outputs(tag);
        for (int a = 0; a < N; a++) mem[a] = 16'h0000;
        wr_pulses   = 0;
        wr_cycles   = 0;
        rd_cycles   = 0;
        mon_viol    = 0;
        next_wr     = 0;
        prev_we_low = 1'b0;
        mon_en      = 1'b1;
        sys_rst     = 1'b0;
    endtask

    // Edge 0 is the first rising edge with reset low.
    task automatic run_to_done(output int done_at);
        done_at = -1;
        for (int k = 0; k < DONE_CYC + 20; k++) begin
            @(posedge sys_clk);
            #1;
            if (test_done) begin
                done_at = k;
                break;
            end
        end
    endtask

    typedef struct {
        bit  s_en;
        int  s_bit;
        bit  i_en;
        int  i_addr;
        int  exp_err;
        bit  exp_pass;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int done_at;
        int found;

        vecs[0] = '{s_en: 0, s_bit: 0, i_en: 0, i_addr: 0, exp_err: 0, exp_pass: 1};
        vecs[1] = '{s_en: 1, s_bit: 0, i_en: 0, i_addr: 0, exp_err: 8, exp_pass: 0};
        vecs[2] = '{s_en: 0, s_bit: 0, i_en: 1, i_addr: 5, exp_err: 1, exp_pass: 0};
        for (int r = 3; r < 7; r++) begin
            vecs[r].s_en   = 1'($urandom_range(0, 1));
            vecs[r].s_bit  = int'($urandom_range(0, 15));
            vecs[r].i_en   = 1'($urandom_range(0, 1));
            vecs[r].i_addr = int'($urandom_range(0, N - 1));
            vecs[r].exp_err  = ref_errs(vecs[r].s_en, vecs[r].s_bit,
                                        vecs[r].i_en, vecs[r].i_addr);
            vecs[r].exp_pass = (vecs[r].exp_err == 0);
        end

        for (int r = 0; r < 7; r++) begin
            string tag;
            tag = $sformatf("v%0d", r);
            stuck_en    = vecs[r].s_en;
            stuck_bit   = 4'(vecs[r].s_bit);
            ignore_en   = vecs[r].i_en;
            ignore_addr = vecs[r].i_addr;
            do_reset({tag, " rst"});
            run_to_done(done_at);
            check({tag, " done_cycle"}, done_at, DONE_CYC);
            check({tag, " err_cnt"},    int'(err_cnt), vecs[r].exp_err);
            check({tag, " test_pass"},  int'(test_pass), int'(vecs[r].exp_pass));
            check({tag, " we_pulses"},  wr_pulses, N);
            check({tag, " wr_cycles"},  wr_cycles, 3 * N);
            check({tag, " rd_cycles"},  rd_cycles, 3 * N);
            check({tag, " protocol"},   mon_viol, 0);
            repeat (10) @(posedge sys_clk);
            #1;
            check({tag, " done_held"},  int'(test_done), 1);
            check({tag, " idle_ctrl"},
                  int'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 31);
        end

        // Reset during the read of address 7, then a full clean rerun.
        stuck_en  = 1'b0;
        ignore_en = 1'b0;
        do_reset("mid rst");
        found = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge sys_clk);
            #1;
            if (!sram_oe_n && int'(sram_addr) == 7) begin
                found = 1;
                break;
            end
        end
        check("mid reach_rd7", found, 1);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check_reset_outputs("mid abort");
        do_reset("mid rerun rst");
        run_to_done(done_at);
        check("mid rerun done_cycle", done_at, DONE_CYC);
        check("mid rerun pass",       int'(test_pass), 1);
        check("mid rerun err_cnt",    int'(err_cnt), 0);
        check("mid rerun protocol",   mon_viol, 0);
        check("mid rerun we_pulses",  wr_pulses, N);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
